skew_feeder: RTL and testbench

SKEW_FEEDER -- requirements
Module: skew_feeder

---
 rtl/skew_feeder.sv | 117 +++++++++++
 tb/tb_skew_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// Skewed tile feeder: loads a LANES x DEPTH tile, then streams it diagonally,
// lane k delayed by k steps, so a systolic array sees a wavefront.
module skew_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LANES  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load_valid,
  output logic                                       load_ready,
  input  logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0]    load_data,
  input  logic                                       en,
  output logic [LANES-1:0][DATA_W-1:0]               out_data,
  output logic [LANES-1:0]                           out_valid,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned RUN_LEN = DEPTH + LANES - 1;
  localparam int unsigned TW      = $clog2(DEPTH + LANES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                                  r_state;
  state_t                                  w_state_nxt;
  logic [TW-1:0]                           r_t;
  logic [TW-1:0]                           w_t_nxt;
  logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0] r_tile;
  logic                                    w_accept;
  logic                                    w_last;
  logic [LANES-1:0][DATA_W-1:0]            w_data_nxt;
  logic [LANES-1:0]                        w_valid_nxt;
  logic                                    w_done_nxt;

  // Next state, step counter and next output values
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_accept    = 1'b0;
    w_last      = (r_t == TW'(RUN_LEN - 1));
    w_data_nxt  = '0;
    w_valid_nxt = '0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
          w_t_nxt     = '0;
        end
      end
      S_RUN: begin
        if (en) begin
          // Lane k shows element t-k while that index lies inside the tile
          for (int k = 0; k < int'(LANES); k++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
              if (int'(r_t) == k + j) begin
                w_data_nxt[k]  = r_tile[k][j];
                w_valid_nxt[k] = 1'b1;
              end
            end
          end
          if (w_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
          end else begin
            w_t_nxt = r_t + TW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Tile is frozen for the whole run; only an accept overwrites it
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_tile <= '0;
    end else if (w_accept) begin
      r_tile <= load_data;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= '0;
      done      <= 1'b0;
    end else begin
      out_data  <= w_data_nxt;
      out_valid <= w_valid_nxt;
      done      <= w_done_nxt;
    end
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: schedule-queue model checked every edge plus
// directed literal expectations, and a DEPTH=1/LANES=1 instance.
module tb_skew_feeder;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int LN = 4;
  localparam int RL = DP + LN - 1;

  logic clk = 1'b1;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                          load_valid = 1'b0;
  logic                          load_ready;
  logic [LN-1:0][DP-1:0][DW-1:0] load_data = '0;
  logic                          en = 1'b0;
  logic [LN-1:0][DW-1:0]         out_data;
  logic [LN-1:0]                 out_valid;
  logic                          busy;
  logic                          done;

  logic                          d_load_valid = 1'b0;
  logic                          d_load_ready;
  logic [0:0][0:0][DW-1:0]       d_load_data = '0;
  logic                          d_en = 1'b0;
  logic [0:0][DW-1:0]            d_out_data;
  logic [0:0]                    d_out_valid;
  logic                          d_busy;
  logic                          d_done;

  skew_feeder #(.DATA_W(DW), .DEPTH(DP), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .en(en), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  skew_feeder #(.DATA_W(DW), .DEPTH(1), .LANES(1)) dut_d (
    .clk(clk), .rst(rst), .load_valid(d_load_valid), .load_ready(d_load_ready),
    .load_data(d_load_data), .en(d_en), .out_data(d_out_data), .out_valid(d_out_valid),
    .busy(d_busy), .done(d_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on accept, precompute the whole diagonal schedule; each enabled edge pops one step
  typedef struct packed {
    logic [LN-1:0][DW-1:0] d;
    logic [LN-1:0]         v;
    logic                  dn;
  } step_t;

  step_t                 q[$];
  logic [LN-1:0][DW-1:0] m_data  = '0;
  logic [LN-1:0]         m_valid = '0;
  logic                  m_done  = 1'b0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_data  = '0;
      m_valid = '0;
      m_done  = 1'b0;
    end else begin
      m_data  = '0;
      m_valid = '0;
      m_done  = 1'b0;
      if (q.size() == 0) begin
        if (load_valid) begin
          for (int t = 0; t < RL; t++) begin
            step_t s;
            s = '0;
            for (int k = 0; k < LN; k++) begin
              if (t - k >= 0 && t - k < DP) begin
                s.d[k] = load_data[k][t-k];
                s.v[k] = 1'b1;
              end
            end
            s.dn = (t == RL - 1);
            q.push_back(s);
          end
        end
      end else if (en) begin
        step_t s;
        s = q.pop_front();
        m_data  = s.d;
        m_valid = s.v;
        m_done  = s.dn;
      end
    end
  end

  // Per-edge comparison against the model
  always @(negedge clk) begin
    #2;
    chk("model_data", 64'(out_data), 64'(m_data));
    chk("model_valid", 64'(out_valid), 64'(m_valid));
    chk("model_done", 64'(done), 64'(m_done));
    chk("model_busy", 64'(busy), 64'(q.size() != 0));
    chk("model_ready", 64'(load_ready), 64'(q.size() == 0));
  end

  task automatic edge_s();
    @(negedge clk);
    #2;
  endtask

  task automatic set_tile(input logic [15:0] base);
    for (int k = 0; k < LN; k++)
      for (int j = 0; j < DP; j++)
        load_data[k][j] = base + 16'(16 * k + j);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) edge_s();
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(load_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("d_rst_ready", 64'(d_load_ready), 64'h1);
    #1 rst = 1'b1;

    // Skew pattern
    set_tile(16'h0000);
    load_valid = 1'b1;
    en = 1'b1;
    edge_s();
    chk("acc_busy", 64'(busy), 64'h1);
    chk("acc_valid", 64'(out_valid), 64'h0);
    load_valid = 1'b0;
    edge_s();
    chk("e1_valid", 64'(out_valid), 64'h1);
    chk("e1_lane0", 64'(out_data[0]), 64'h00);
    repeat (3) edge_s();
    chk("e4_valid", 64'(out_valid), 64'hF);
    chk("e4_data", 64'(out_data), 64'h0030_0021_0012_0003);
    chk("e4_done", 64'(done), 64'h0);
    repeat (3) edge_s();
    chk("e7_valid", 64'(out_valid), 64'h8);
    chk("e7_lane3", 64'(out_data[3]), 64'h33);
    chk("e7_done", 64'(done), 64'h1);
    chk("e7_ready", 64'(load_ready), 64'h1);
    edge_s();
    chk("idle_done", 64'(done), 64'h0);

    // Stall: two bubbles after edge2
    set_tile(16'h0100);
    load_valid = 1'b1;
    edge_s();
    load_valid = 1'b0;
    repeat (2) edge_s();
    en = 1'b0;
    repeat (2) edge_s();
    chk("bub_valid", 64'(out_valid), 64'h0);
    chk("bub_busy", 64'(busy), 64'h1);
    en = 1'b1;
    edge_s();
    chk("e5_valid", 64'(out_valid), 64'h7);
    chk("e5_data", 64'(out_data), 64'h0000_0120_0111_0102);
    repeat (3) edge_s();
    chk("e8_done", 64'(done), 64'h0);
    edge_s();
    chk("e9_done", 64'(done), 64'h1);

    // Back-to-back with load_valid held high; second tile offered during RUN
    set_tile(16'h0200);
    load_valid = 1'b1;
    edge_s();
    set_tile(16'h0300);
    repeat (4) edge_s();
    chk("b2b_e4_lane0", 64'(out_data[0]), 64'h0203);
    repeat (3) edge_s();
    chk("b2b_e7_done", 64'(done), 64'h1);
    edge_s();
    chk("b2b_acc_busy", 64'(busy), 64'h1);
    chk("b2b_acc_valid", 64'(out_valid), 64'h0);
    load_valid = 1'b0;
    edge_s();
    chk("b2b_e1_lane0", 64'(out_data[0]), 64'h0300);
    repeat (6) edge_s();
    chk("b2b2_done", 64'(done), 64'h1);

    // Reset mid-run at t=3
    set_tile(16'h0400);
    load_valid = 1'b1;
    edge_s();
    load_valid = 1'b0;
    repeat (3) edge_s();
    #1 rst = 1'b0;
    #1;
    chk("mr_data", 64'(out_data), 64'h0);
    chk("mr_valid", 64'(out_valid), 64'h0);
    chk("mr_ready", 64'(load_ready), 64'h1);
    chk("mr_busy", 64'(busy), 64'h0);
    repeat (5) begin
      edge_s();
      chk("mr_no_done", 64'(done), 64'h0);
    end
    #1 rst = 1'b1;
    set_tile(16'h0500);
    load_valid = 1'b1;
    edge_s();
    chk("mr_acc_busy", 64'(busy), 64'h1);
    load_valid = 1'b0;
    edge_s();
    chk("mr_e1_lane0", 64'(out_data[0]), 64'h0500);
    repeat (6) edge_s();
    chk("mr_done", 64'(done), 64'h1);

    // Degenerate DEPTH=1, LANES=1
    d_load_data[0][0] = 16'hBEEF;
    d_load_valid = 1'b1;
    edge_s();
    chk("d_acc_busy", 64'(d_busy), 64'h1);
    chk("d_acc_valid", 64'(d_out_valid), 64'h0);
    d_load_valid = 1'b0;
    d_en = 1'b1;
    edge_s();
    chk("d_e1_valid", 64'(d_out_valid), 64'h1);
    chk("d_e1_data", 64'(d_out_data[0]), 64'hBEEF);
    chk("d_e1_done", 64'(d_done), 64'h1);
    chk("d_e1_ready", 64'(d_load_ready), 64'h1);
    edge_s();
    chk("d_post_done", 64'(d_done), 64'h0);
    chk("d_post_valid", 64'(d_out_valid), 64'h0);

    edge_s();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
